// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: op codes, FSM states and the
// single-cycle combinational ALU function used by alu_pipe.
package alu_pkg;

    // Widest datapath alu_comb supports; narrower XLEN values are extended on entry.
    localparam int ALU_MAXW = 64;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SLL  = 4'h3;
    localparam logic [3:0] OP_SRL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_AND  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

    // Operands arrive sign-extended to ALU_MAXW; zero-extended copies are rebuilt
    // from xlen for the unsigned ops. Callers keep the low xlen bits.
    function automatic logic [ALU_MAXW-1:0] alu_comb(
        input logic [3:0]          op,
        input logic [ALU_MAXW-1:0] a,
        input logic [ALU_MAXW-1:0] b,
        input int unsigned         xlen
    );
        logic [ALU_MAXW-1:0] mask;
        logic [ALU_MAXW-1:0] a_z;
        logic [ALU_MAXW-1:0] b_z;
        int unsigned         shamt;
        logic [ALU_MAXW-1:0] r;

        mask  = (xlen >= 32'(ALU_MAXW)) ? '1 : ((ALU_MAXW'(1) << xlen) - ALU_MAXW'(1));
        a_z   = a & mask;
        b_z   = b & mask;
        shamt = 32'(b[5:0]) & (xlen - 32'd1);

        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << shamt;
            OP_SRL:  r = a_z >> shamt;
            OP_SRA:  r = ALU_MAXW'($signed(a) >>> shamt);
            OP_SLT:  r = {{(ALU_MAXW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(ALU_MAXW-1){1'b0}}, (a_z < b_z)};
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = '1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, stopping as
// soon as no multiplier bits remain. done pulses in the cycle product is final.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] mcand_in,
    input  logic [XLEN-1:0] mplier_in,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic             active;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // product already folds in this cycle's partial sum, so the final
    // iteration and the result load happen on the same edge.
    assign product = mplier[0] ? (acc + mcand) : acc;
    assign last    = ((mplier >> 1) == '0) || (cnt == CNT_W'(XLEN - 1));
    assign done    = active && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (active) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute unit: single-cycle ALU ops plus an iterative multiply,
// with a result register that holds until the consumer takes it.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            flag_zero,
    output logic            flag_neg,
    output logic            flag_ill
);

    localparam int SHAMT_W = $clog2(XLEN);

    state_t              state;
    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [XLEN-1:0]     mul_product;
    logic [XLEN-1:0]     alu_res;
    logic [ALU_MAXW-1:0] a_ext;
    logic [ALU_MAXW-1:0] b_ext;

    // A slot that is being drained this cycle counts as free.
    assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    assign a_ext   = ALU_MAXW'($signed(rs1));
    assign b_ext   = ALU_MAXW'($signed(rs2));
    assign alu_res = XLEN'(alu_comb(op, a_ext, b_ext, XLEN));

    alu_mul_iter #(
        .XLEN  (XLEN),
        .CNT_W (SHAMT_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .mcand_in  (rs1),
        .mplier_in (rs2),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
            flag_ill  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        flag_ill <= !op_legal(op);
                        if (op == OP_MUL) begin
                            state <= MUL;
                        end else begin
                            result    <= alu_res;
                            out_valid <= 1'b1;
                            flag_zero <= (alu_res == '0);
                            flag_neg  <= alu_res[XLEN-1];
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        out_valid <= 1'b1;
                        flag_zero <= (mul_product == '0);
                        flag_neg  <= mul_product[XLEN-1];
                        flag_ill  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
